vga_fb_arbiter: RTL and testbench

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_fb_arbiter_if.sv | 31 +++
 rtl/vga_fb_addr_gen.sv | 23 ++
 rtl/vga_fb_arbiter.sv | 127 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants and the arbiter slot classification.
package vga_pkg;

  // 640x480 visible area, two RGB565 pixels per 32-bit framebuffer word.
  localparam int unsigned C_H_VISIBLE  = 640;
  localparam int unsigned C_V_VISIBLE  = 480;
  localparam int unsigned C_LINE_PITCH = C_H_VISIBLE / 2;
  localparam int unsigned C_FB_WORDS   = C_LINE_PITCH * C_V_VISIBLE;

  // RGB565 field widths.
  localparam int unsigned C_R_W   = 5;
  localparam int unsigned C_G_W   = 6;
  localparam int unsigned C_B_W   = 5;
  localparam int unsigned C_PIX_W = C_R_W + C_G_W + C_B_W;

  // Bus widths.
  localparam int unsigned C_ADDR_W  = 18;
  localparam int unsigned C_DATA_W  = 32;
  localparam int unsigned C_COORD_W = 10;

  // What the memory port is used for in a given cycle.
  typedef enum logic [1:0] {
    SLOT_IDLE,   // write slot with no pending request (or reset)
    SLOT_READ,   // even visible pixel: fetch the next pixel word
    SLOT_WRITE,  // writer request granted and in range
    SLOT_WERR    // writer request granted but out of range: ack only
  } slot_e;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer memory bus plus writer request/ack handshake.
interface vga_fb_arbiter_if;
  import vga_pkg::*;

  // Memory side
  logic [C_ADDR_W-1:0] oMemAddr;
  logic                oMemRd;
  logic                oMemWe;
  logic [C_DATA_W-1:0] oMemWData;
  logic [C_DATA_W-1:0] iMemRData;

  // Writer side
  logic                iWrReq;
  logic [C_ADDR_W-1:0] iWrAddr;
  logic [C_DATA_W-1:0] iWrData;
  logic                oWrAck;
  logic                oWrErr;

  // Arbiter view
  modport master (
    output oMemAddr, oMemRd, oMemWe, oMemWData, oWrAck, oWrErr,
    input  iMemRData, iWrReq, iWrAddr, iWrData
  );

  // Memory/writer environment view
  modport slave (
    input  oMemAddr, oMemRd, oMemWe, oMemWData, oWrAck, oWrErr,
    output iMemRData, iWrReq, iWrAddr, iWrData
  );

endinterface

// File: rtl/vga_fb_addr_gen.sv
// Combinational pixel-word address: FB_BASE + y*320 + x/2, multiplier-free.
module vga_fb_addr_gen
  import vga_pkg::*;
#(
  parameter int unsigned FB_BASE = 0
) (
  input  logic [C_COORD_W-1:0] i_y,
  input  logic [C_COORD_W-2:0] i_xw,
  output logic [C_ADDR_W-1:0]  o_addr
);

  logic [C_ADDR_W-1:0] w_y_ext;
  logic [C_ADDR_W-1:0] w_row;

  // Row offset y*320 as (y<<8)+(y<<6), then add base and word column.
  always_comb begin
    w_y_ext = {{(C_ADDR_W-C_COORD_W){1'b0}}, i_y};
    w_row   = (w_y_ext << 8) + (w_y_ext << 6);
    o_addr  = C_ADDR_W'(FB_BASE) + w_row
            + {{(C_ADDR_W-C_COORD_W+1){1'b0}}, i_xw};
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Time-slot arbiter sharing one framebuffer port between the display
// scan-out (even visible pixels) and a writer (all other cycles).
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned FB_BASE  = 0,
  parameter int unsigned FB_WORDS = C_FB_WORDS
) (
  input  logic                 CLK_25,
  input  logic                 nRst,
  input  logic [C_COORD_W-1:0] iX,
  input  logic [C_COORD_W-1:0] iY,
  input  logic                 iImValid,
  vga_fb_arbiter_if.master     bus,
  output logic [C_PIX_W-1:0]   oPixel,
  output logic                 oPixValid,
  output logic                 oFrameStart
);

  slot_e               w_slot;
  logic                w_wr_err;
  logic [C_ADDR_W-1:0] w_rd_addr;
  logic [C_ADDR_W-1:0] w_wr_addr;
  logic [C_ADDR_W-1:0] w_mem_addr;
  logic                w_mem_rd;
  logic                w_mem_we;
  logic [C_DATA_W-1:0] w_mem_wdata;
  logic                w_wr_ack;

  logic [C_ADDR_W-1:0] r_last_addr;
  logic                r_rd_d1;
  logic [C_DATA_W-1:0] r_word;
  logic                r_val_d1;
  logic                r_val_d2;
  logic                r_odd_d1;
  logic                r_odd_d2;
  logic                r_frame_start;

  vga_fb_addr_gen #(
    .FB_BASE (FB_BASE)
  ) u_addr_gen (
    .i_y    (iY),
    .i_xw   (iX[C_COORD_W-1:1]),
    .o_addr (w_rd_addr)
  );

  // Classify the cycle; reset forces the idle slot so every strobe stays low.
  always_comb begin
    w_wr_err  = ({{(32-C_ADDR_W){1'b0}}, bus.iWrAddr} >= FB_WORDS);
    w_wr_addr = C_ADDR_W'(FB_BASE) + bus.iWrAddr;
    w_slot    = SLOT_IDLE;
    if (!nRst)                     w_slot = SLOT_IDLE;
    else if (iImValid && !iX[0])   w_slot = SLOT_READ;
    else if (bus.iWrReq)           w_slot = w_wr_err ? SLOT_WERR : SLOT_WRITE;
  end

  // Drive the memory port and writer handshake from the slot type.
  always_comb begin
    w_mem_addr  = r_last_addr;
    w_mem_rd    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_wdata = '0;
    w_wr_ack    = 1'b0;
    unique case (w_slot)
      SLOT_READ: begin
        w_mem_rd   = 1'b1;
        w_mem_addr = w_rd_addr;
      end
      SLOT_WRITE: begin
        w_mem_we    = 1'b1;
        w_wr_ack    = 1'b1;
        w_mem_addr  = w_wr_addr;
        w_mem_wdata = bus.iWrData;
      end
      SLOT_WERR: w_wr_ack = 1'b1;
      default:   ;
    endcase
    bus.oMemAddr  = w_mem_addr;
    bus.oMemRd    = w_mem_rd;
    bus.oMemWe    = w_mem_we;
    bus.oMemWData = w_mem_wdata;
    bus.oWrAck    = w_wr_ack;
    bus.oWrErr    = (w_slot == SLOT_WERR);
  end

  // Hold the last issued address so idle slots do not disturb the bus.
  always_ff @(posedge CLK_25 or negedge nRst) begin
    if (!nRst)
      r_last_addr <= '0;
    else if (w_slot == SLOT_READ || w_slot == SLOT_WRITE)
      r_last_addr <= w_mem_addr;
  end

  // Pixel pipeline: capture the read word one cycle after the read slot,
  // then present the even half at +2 and the odd half at +3 so both
  // pixels see the same latency of 2 relative to their own (X,Y).
  always_ff @(posedge CLK_25 or negedge nRst) begin
    if (!nRst) begin
      r_rd_d1       <= 1'b0;
      r_word        <= '0;
      r_val_d1      <= 1'b0;
      r_val_d2      <= 1'b0;
      r_odd_d1      <= 1'b0;
      r_odd_d2      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_rd_d1       <= (w_slot == SLOT_READ);
      r_val_d1      <= iImValid;
      r_val_d2      <= r_val_d1;
      r_odd_d1      <= iX[0];
      r_odd_d2      <= r_odd_d1;
      r_frame_start <= iImValid && (iX == '0) && (iY == '0);
      if (r_rd_d1)
        r_word <= bus.iMemRData;
    end
  end

  // Select the pixel half; blank outside the visible area.
  always_comb begin
    oPixel = '0;
    if (r_val_d2)
      oPixel = r_odd_d2 ? r_word[C_DATA_W-1:C_PIX_W] : r_word[C_PIX_W-1:0];
    oPixValid   = r_val_d2;
    oFrameStart = r_frame_start;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: per-cycle reference model for the
// bus/handshake outputs plus a latency-2 pixel scoreboard.
module tb_vga_fb_arbiter;

  localparam int unsigned P_FB_BASE  = 0;
  localparam int unsigned P_FB_WORDS = 153600;

  typedef struct packed {
    logic        chk;
    logic        vld;
    logic [15:0] pix;
  } pexp_t;

  logic        CLK_25;
  logic        nRst;
  logic [9:0]  iX;
  logic [9:0]  iY;
  logic        iImValid;
  logic [15:0] oPixel;
  logic        oPixValid;
  logic        oFrameStart;

  vga_fb_arbiter_if bus ();

  vga_fb_arbiter #(
    .FB_BASE  (P_FB_BASE),
    .FB_WORDS (P_FB_WORDS)
  ) dut (
    .CLK_25      (CLK_25),
    .nRst        (nRst),
    .iX          (iX),
    .iY          (iY),
    .iImValid    (iImValid),
    .bus         (bus),
    .oPixel      (oPixel),
    .oPixValid   (oPixValid),
    .oFrameStart (oFrameStart)
  );

  initial begin
    CLK_25 = 1'b0;
    forever #20 CLK_25 = ~CLK_25;
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  pexp_t       q[$];
  logic        pend_rd      = 1'b0;
  logic [17:0] pend_addr    = '0;
  logic [17:0] model_last   = '0;
  logic        prev_rd_exp  = 1'b0;
  logic [17:0] prev_rd_addr = '0;
  logic        prev_fs_cond = 1'b0;
  logic        obs_rd, obs_we, obs_ack, obs_err, obs_pv, obs_fs;
  logic [17:0] obs_addr;
  logic [15:0] obs_pix;
  int          n_ack, n_we, n_rd, n_fs;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: word 0 is the red/blue test word, others address-derived.
  function automatic logic [31:0] mem_word(input logic [17:0] a);
    if (a == 18'd0) return 32'hF800_001F;
    return {a[15:0] ^ 16'h5A3C, a[15:0] + 16'h0101};
  endfunction

  // One clock cycle: drive inputs, check outputs late in the cycle, advance.
  task automatic cycle(input logic nrst, input logic v, input logic [9:0] x,
                       input logic [9:0] y, input logic wrreq,
                       input logic [17:0] wa, input logic [31:0] wd);
    logic        exp_rd, exp_ack, exp_err, exp_we, exp_fs;
    logic [17:0] exp_addr;
    int unsigned t;
    pexp_t       e;
    nRst          = nrst;
    iX            = x;
    iY            = y;
    iImValid      = v;
    bus.iWrReq    = wrreq;
    bus.iWrAddr   = wa;
    bus.iWrData   = wd;
    bus.iMemRData = pend_rd ? mem_word(pend_addr) : $urandom;
    #18;
    exp_rd  = nrst && v && !x[0];
    exp_ack = nrst && !exp_rd && wrreq;
    exp_err = exp_ack && ({14'b0, wa} >= P_FB_WORDS);
    exp_we  = exp_ack && !exp_err;
    if (exp_rd) begin
      t = P_FB_BASE + y * 320 + x / 2;
      exp_addr = t[17:0];
    end else if (exp_we) begin
      t = P_FB_BASE + wa;
      exp_addr = t[17:0];
    end else begin
      exp_addr = nrst ? model_last : 18'd0;
    end
    if (!nrst) model_last = '0;
    else if (exp_rd || exp_we) model_last = exp_addr;

    chk("rd",   {31'b0, bus.oMemRd}, {31'b0, exp_rd});
    chk("we",   {31'b0, bus.oMemWe}, {31'b0, exp_we});
    chk("ack",  {31'b0, bus.oWrAck}, {31'b0, exp_ack});
    chk("err",  {31'b0, bus.oWrErr}, {31'b0, exp_err});
    chk("addr", {14'b0, bus.oMemAddr}, {14'b0, exp_addr});
    chk("rdwe_excl", {31'b0, bus.oMemRd & bus.oMemWe}, 32'd0);
    if (exp_we) chk("wdata", bus.oMemWData, wd);

    exp_fs = prev_fs_cond && nrst;
    chk("frame_start", {31'b0, oFrameStart}, {31'b0, exp_fs});
    prev_fs_cond = nrst && v && (x == 10'd0) && (y == 10'd0);

    // Pixel scoreboard: front entry is the expectation for this cycle.
    if (!nrst) begin
      q.delete();
      e = '{chk: 1'b1, vld: 1'b0, pix: 16'h0};
      q.push_back(e);
      q.push_back(e);
    end
    if (q.size() == 0) begin
      chk("pix_queue", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      if (e.chk) begin
        chk("pix_valid", {31'b0, oPixValid}, {31'b0, e.vld});
        chk("pixel",     {16'b0, oPixel},    {16'b0, e.pix});
      end
    end
    if (nrst && v) begin
      if (!x[0])           e = '{chk: 1'b1, vld: 1'b1, pix: mem_word(exp_addr) & 32'hFFFF};
      else if (prev_rd_exp) e = '{chk: 1'b1, vld: 1'b1, pix: mem_word(prev_rd_addr) >> 16};
      else                 e = '{chk: 1'b0, vld: 1'b1, pix: 16'h0};
    end else begin
      e = '{chk: 1'b1, vld: 1'b0, pix: 16'h0};
    end
    q.push_back(e);
    prev_rd_exp  = exp_rd;
    prev_rd_addr = exp_addr;

    obs_rd   = bus.oMemRd;
    obs_we   = bus.oMemWe;
    obs_ack  = bus.oWrAck;
    obs_err  = bus.oWrErr;
    obs_addr = bus.oMemAddr;
    obs_pix  = oPixel;
    obs_pv   = oPixValid;
    obs_fs   = oFrameStart;
    pend_rd   = bus.oMemRd;
    pend_addr = bus.oMemAddr;
    @(posedge CLK_25);
    #1;
  endtask

  initial begin
    nRst = 1'b0; iX = '0; iY = '0; iImValid = 1'b0;
    bus.iWrReq = 1'b0; bus.iWrAddr = '0; bus.iWrData = '0; bus.iMemRData = '0;
    @(posedge CLK_25);
    #1;

    // Reset with activity on the inputs: everything must stay at zero.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b1, 10'(i), 10'd0, 1'b1, 18'd7, $urandom);

    // First line start: reads at even X, acks at odd X, red/blue pixel word.
    for (int x = 0; x < 16; x++) begin
      cycle(1'b1, 1'b1, 10'(x), 10'd0, (x < 4) ? 1'b1 : 1'($urandom),
            18'($urandom_range(0, 153599)), $urandom);
      if (x < 4) begin
        chk("slot_rd_x",  {31'b0, obs_rd},  {31'b0, ~x[0]});
        chk("slot_ack_x", {31'b0, obs_ack}, {31'b0, x[0]});
      end
      if (x == 1) chk("fs_after_00", {31'b0, obs_fs}, 32'd1);
      if (x == 2) begin
        chk("pix00_even", {16'b0, obs_pix}, 32'h001F);
        chk("pix00_even_v", {31'b0, obs_pv}, 32'd1);
      end
      if (x == 3) begin
        chk("pix00_odd", {16'b0, obs_pix}, 32'hF800);
        chk("pix00_odd_v", {31'b0, obs_pv}, 32'd1);
      end
    end
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 10'(640 + i), 10'd0, 1'b0, '0, '0);

    // Last visible line end and the framebuffer address boundary.
    for (int x = 630; x < 640; x++) begin
      cycle(1'b1, 1'b1, 10'(x), 10'd479, 1'b1, 18'(x * 3), $urandom);
      if (x == 638) chk("addr_last_word", {14'b0, obs_addr}, 32'd153599);
    end
    cycle(1'b1, 1'b0, 10'd640, 10'd479, 1'b1, 18'd153600, 32'hDEAD_BEEF);
    chk("oob_ack", {31'b0, obs_ack}, 32'd1);
    chk("oob_err", {31'b0, obs_err}, 32'd1);
    chk("oob_we",  {31'b0, obs_we},  32'd0);
    cycle(1'b1, 1'b0, 10'd641, 10'd479, 1'b1, 18'd153599, 32'h1234_5678);
    chk("edge_err", {31'b0, obs_err}, 32'd0);
    chk("edge_we",  {31'b0, obs_we},  32'd1);

    // Blanking burst: writer owns every cycle.
    n_ack = 0; n_we = 0; n_rd = 0;
    for (int i = 0; i < 160; i++) begin
      cycle(1'b1, 1'b0, 10'(642 + i), 10'd479, 1'b1,
            18'($urandom_range(0, 153599)), $urandom);
      n_ack += int'(obs_ack);
      n_we  += int'(obs_we);
      n_rd  += int'(obs_rd);
    end
    chk("blank_acks", n_ack, 32'd160);
    chk("blank_we",   n_we,  32'd160);
    chk("blank_rd",   n_rd,  32'd0);

    // Mid-line reset right after a read slot, writer request held throughout.
    for (int x = 100; x < 107; x++)
      cycle(1'b1, 1'b1, 10'(x), 10'd5, 1'b1, 18'(x), $urandom);
    for (int x = 107; x < 110; x++) begin
      cycle(1'b0, 1'b1, 10'(x), 10'd5, 1'b1, 18'(x), $urandom);
      chk("rst_ack", {31'b0, obs_ack}, 32'd0);
      chk("rst_pix", {15'b0, obs_pv, obs_pix}, 32'd0);
    end
    cycle(1'b1, 1'b1, 10'd110, 10'd5, 1'b1, 18'd110, $urandom);
    chk("rel_read_noack", {31'b0, obs_ack}, 32'd0);
    cycle(1'b1, 1'b1, 10'd111, 10'd5, 1'b1, 18'd111, $urandom);
    chk("rel_first_ack", {31'b0, obs_ack}, 32'd1);
    for (int x = 112; x < 120; x++)
      cycle(1'b1, 1'b1, 10'(x), 10'd5, 1'b1, 18'(x), $urandom);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 10'(700 + i), 10'd524, 1'b0, '0, '0);

    // Next frame start: exactly one frame-start pulse.
    n_fs = 0;
    for (int x = 0; x < 6; x++) begin
      cycle(1'b1, 1'b1, 10'(x), 10'd0, 1'($urandom), 18'(x + 40), $urandom);
      n_fs += int'(obs_fs);
    end
    chk("fs_count", n_fs, 32'd1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 1'b0, 10'(640 + i), 10'd0, 1'b0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
